// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS board debug/run controller: state encodings
// and the default timing constants for the 50 MHz board clock.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_e;

  // 1 Hz core rate and 20 ms button debounce at 50 MHz
  localparam int unsigned DEF_RUN_DIV    = 50_000_000;
  localparam int unsigned DEF_DEB_CYCLES = 1_000_000;
  localparam int unsigned DEF_PC_W       = 32;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_debounce.sv
// Step push-button conditioning: 2-flop synchroniser, stability counter and
// a single-cycle request on each accepted press (rising edge of the
// debounced level). Releases are debounced too but produce no request.
module step_debounce
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic step_i,
  output logic step_req_o
);

  localparam int unsigned   CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          step_m;
  logic          step_s;
  logic          level_q;
  logic          req_q;
  logic [CW-1:0] cnt_q;
  logic          differ;
  logic          accept;

  assign differ = (step_s != level_q);
  assign accept = differ && (cnt_q == CNT_LAST);

  // Bring the raw button into the clk_i domain
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      step_m <= 1'b0;
      step_s <= 1'b0;
    end else begin
      step_m <= step_i;
      step_s <= step_m;
    end
  end

  // Accept a new level only after it has been stable for DEB_CYCLES cycles
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      req_q <= accept && step_s;
      if (!differ) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q   <= '0;
        level_q <= step_s;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign step_req_o = req_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/step/breakpoint sequencer producing the MIPS core clock enable.
// The core runs on clk_i and advances only in cycles where cpu_ce_o is high.
//
//   state | meaning
//   HALT  | core frozen, waiting for run switch or step press
//   RUN   | free-run, one cpu_ce_o pulse every RUN_DIV cycles
//   STEP  | single cycle; schedules exactly one pulse, then HALT
//   BREAK | stopped on PC breakpoint; step moves past it, run does not resume
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned RUN_DIV    = DEF_RUN_DIV,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned PC_W       = DEF_PC_W
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            run_i,
  input  logic            step_i,
  input  logic            bp_en_i,
  input  logic [PC_W-1:0] bp_addr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            cpu_ce_o,
  output logic            halted_o,
  output logic            bp_hit_o,
  output logic [1:0]      state_o
);

  localparam int unsigned   DW       = cnt_width(RUN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  logic          run_m;
  logic          run_s;
  logic          step_req;
  logic [DW-1:0] div_q;
  logic          tick;
  logic          bp_match;

  run_state_e    state_q;
  run_state_e    state_d;
  logic          ce_d;
  logic          ce_q;
  logic          halted_q;
  logic          bp_hit_q;

  step_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_debounce (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .step_i     (step_i),
    .step_req_o (step_req)
  );

  // Bring the run switch into the clk_i domain
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      run_m <= 1'b0;
      run_s <= 1'b0;
    end else begin
      run_m <= run_i;
      run_s <= run_m;
    end
  end

  // Rate divider: held at zero outside RUN so every run starts a full period
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      div_q <= '0;
    end else if (state_q != ST_RUN) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  assign tick     = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign bp_match = bp_en_i && (pc_i == bp_addr_i);

  // State register plus registered outputs, all decoded from the next state
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_HALT;
      ce_q     <= 1'b0;
      halted_q <= 1'b1;
      bp_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ce_q     <= ce_d;
      halted_q <= (state_d != ST_RUN);
      bp_hit_q <= (state_d == ST_BREAK);
    end
  end

  // Next state and pulse request; checks are ordered by priority within each state
  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (run_s) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!run_s) begin
          state_d = ST_HALT;
        end else if (tick) begin
          if (bp_match) begin
            state_d = ST_BREAK;
          end else begin
            ce_d = 1'b1;
          end
        end
      end
      ST_STEP: begin
        ce_d    = 1'b1;
        state_d = ST_HALT;
      end
      ST_BREAK: begin
        if (!run_s) begin
          state_d = ST_HALT;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  assign cpu_ce_o = ce_q;
  assign halted_o = halted_q;
  assign bp_hit_o = bp_hit_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with RUN_DIV=4, DEB_CYCLES=3, PC_W=32.
module tb_mips_run_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        run_i;
  logic        step_i;
  logic        bp_en_i;
  logic [31:0] bp_addr_i;
  logic [31:0] pc;
  logic        cpu_ce_o;
  logic        halted_o;
  logic        bp_hit_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  mips_run_ctrl #(
    .RUN_DIV    (4),
    .DEB_CYCLES (3),
    .PC_W       (32)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .run_i     (run_i),
    .step_i    (step_i),
    .bp_en_i   (bp_en_i),
    .bp_addr_i (bp_addr_i),
    .pc_i      (pc),
    .cpu_ce_o  (cpu_ce_o),
    .halted_o  (halted_o),
    .bp_hit_o  (bp_hit_o),
    .state_o   (state_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Advance n cycles, sampling 1 time unit after each edge; a pulse advances the core PC
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      if (cpu_ce_o) begin
        pulses++;
        pc = pc + 32'd4;
      end
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b0; run_i = 1'b0; step_i = 1'b0; bp_en_i = 1'b0;
    bp_addr_i = 32'h0; pc = 32'h0;
    tick(3);
    checks++;
    if (state_o !== 2'd0 || halted_o !== 1'b1 || cpu_ce_o !== 1'b0 || bp_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d halted=%b ce=%b bp=%b want 0/1/0/0", state_o, halted_o, cpu_ce_o, bp_hit_o);
    end
    reset_i = 1'b1;
    pulses = 0;
    tick(100);
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL idle_pulses: got %0d want 0", pulses);
    end
    checks++;
    if (state_o !== 2'd0 || halted_o !== 1'b1 || bp_hit_o !== 1'b0) begin
      errors++; $display("FAIL idle_state: state=%0d halted=%b bp=%b want 0/1/0", state_o, halted_o, bp_hit_o);
    end
  endtask

  task automatic test_run;
    int last;
    run_i = 1'b1;
    tick(3);
    checks++;
    if (state_o !== 2'd1 || halted_o !== 1'b0) begin
      errors++; $display("FAIL run_enter: state=%0d halted=%b want 1/0", state_o, halted_o);
    end
    pulses = 0;
    last = -1;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (cpu_ce_o) begin
        if (last >= 0) begin
          checks++;
          if (i - last !== 4) begin
            errors++; $display("FAIL run_period: got %0d want 4", i - last);
          end
        end
        last = i;
      end
    end
    checks++;
    if (pulses !== 6) begin
      errors++; $display("FAIL run_count: got %0d want 6", pulses);
    end
    run_i = 1'b0;
    tick(4);
    pulses = 0;
    tick(20);
    checks++;
    if (pulses !== 0 || state_o !== 2'd0 || halted_o !== 1'b1) begin
      errors++; $display("FAIL run_stop: pulses=%0d state=%0d halted=%b want 0/0/1", pulses, state_o, halted_o);
    end
  endtask

  task automatic test_step;
    pulses = 0;
    step_i = 1'b1; tick(1); step_i = 1'b0; tick(12);
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL glitch1: got %0d pulses want 0", pulses);
    end
    step_i = 1'b1; tick(2); step_i = 1'b0; tick(12);
    checks++;
    if (pulses !== 0 || state_o !== 2'd0) begin
      errors++; $display("FAIL glitch2: pulses=%0d state=%0d want 0/0", pulses, state_o);
    end
    step_i = 1'b1; tick(10); step_i = 1'b0; tick(12);
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL step_held: got %0d pulses want 1", pulses);
    end
    checks++;
    if (state_o !== 2'd0 || halted_o !== 1'b1) begin
      errors++; $display("FAIL step_after: state=%0d halted=%b want 0/1", state_o, halted_o);
    end
  endtask

  task automatic test_breakpoint;
    bit seen;
    pc = 32'h0040_0000;
    bp_addr_i = 32'h0040_0008;
    bp_en_i = 1'b1;
    pulses = 0;
    run_i = 1'b1;
    for (int i = 0; i < 40 && state_o != 2'd3; i++) tick(1);
    checks++;
    if (pulses !== 2) begin
      errors++; $display("FAIL bp_pulses: got %0d want 2", pulses);
    end
    checks++;
    if (state_o !== 2'd3 || bp_hit_o !== 1'b1 || halted_o !== 1'b1) begin
      errors++; $display("FAIL bp_state: state=%0d bp=%b halted=%b want 3/1/1", state_o, bp_hit_o, halted_o);
    end
    pulses = 0;
    tick(50);
    checks++;
    if (pulses !== 0 || state_o !== 2'd3) begin
      errors++; $display("FAIL bp_hold: pulses=%0d state=%0d want 0/3", pulses, state_o);
    end
    seen = 1'b0;
    step_i = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (i == 10) step_i = 1'b0;
      tick(1);
      seen = cpu_ce_o;
    end
    step_i = 1'b0;
    checks++;
    if (!seen || pulses !== 1 || pc !== 32'h0040_000C) begin
      errors++; $display("FAIL bp_step: seen=%b pulses=%0d pc=%h want 1/1/0040000c", seen, pulses, pc);
    end
    checks++;
    if (state_o !== 2'd0) begin
      errors++; $display("FAIL bp_step_state: got %0d want 0", state_o);
    end
    tick(1);
    checks++;
    if (state_o !== 2'd1 || bp_hit_o !== 1'b0) begin
      errors++; $display("FAIL bp_resume: state=%0d bp=%b want 1/0", state_o, bp_hit_o);
    end
    pulses = 0;
    for (int i = 0; i < 8 && pulses == 0; i++) tick(1);
    checks++;
    if (pulses !== 1 || pc !== 32'h0040_0010) begin
      errors++; $display("FAIL bp_continue: pulses=%0d pc=%h want 1/00400010", pulses, pc);
    end
    run_i = 1'b0; bp_en_i = 1'b0;
    tick(20);
  endtask

  task automatic test_priority;
    bit seen;
    run_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = cpu_ce_o;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL prio_first_pulse: timeout got 0 want 1");
    end
    tick(1);
    run_i = 1'b0;
    pulses = 0;
    tick(10);
    checks++;
    if (pulses !== 0 || state_o !== 2'd0) begin
      errors++; $display("FAIL drop_on_tick: pulses=%0d state=%0d want 0/0", pulses, state_o);
    end
    step_i = 1'b1;
    tick(3);
    run_i = 1'b1;
    pulses = 0;
    tick(3);
    checks++;
    if (state_o !== 2'd1) begin
      errors++; $display("FAIL run_beats_step: state=%0d want 1", state_o);
    end
    tick(3);
    checks++;
    if (pulses !== 0 || state_o !== 2'd1) begin
      errors++; $display("FAIL step_dropped: pulses=%0d state=%0d want 0/1", pulses, state_o);
    end
    step_i = 1'b0;
    run_i = 1'b0;
    tick(20);
  endtask

  task automatic test_reset_mid_pulse;
    bit seen;
    run_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = cpu_ce_o;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_pulse_wait: timeout got 0 want 1");
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (cpu_ce_o !== 1'b0 || state_o !== 2'd0 || halted_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pulse: ce=%b state=%0d halted=%b want 0/0/1", cpu_ce_o, state_o, halted_o);
    end
    run_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    pulses = 0;
    tick(10);
    checks++;
    if (pulses !== 0 || state_o !== 2'd0) begin
      errors++; $display("FAIL rst_after: pulses=%0d state=%0d want 0/0", pulses, state_o);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_priority();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
